// File: rtl/home_event_arbiter.sv
// Purpose : debounce home sensors, latch pending events, grant one at a time (fire preempts, others round-robin).
// Latency : raw change -> grant_valid after DEB_CYC+1 edges; preempt -> fire grant 3 edges after fire pends.
// Backpressure: a grant is held until acked after HOLD_CYC cycles, or force-released after TIMEOUT_CYC cycles.
//
// Ports:
//   Clk, Rst            rising-edge clock, asynchronous active-low reset
//   SFD, SRD, SW, SFA   front door, rear door, window, fire sensors (levels)
//   ST                  7-bit unsigned temperature, out-of-band is an event source
//   ack                 controller accepted the granted event (ignored while grant_valid=0)
//   grant, grant_valid  one-hot grant [0]front [1]rear [2]window [3]temp [4]fire
//   svc_code            0 idle, 1 front, 2 rear, 3 window, 4 fire, 5 temp
//   pending             latched pending events, same bit order as grant
//   timeout_err         one-cycle pulse on forced release
module home_event_arbiter #(
  parameter int         HOLD_CYC    = 8,
  parameter int         TIMEOUT_CYC = 255,
  parameter int         DEB_CYC     = 3,
  parameter logic [6:0] T_LOW       = 7'd50,
  parameter logic [6:0] T_HIGH      = 7'd85
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       SFD,
  input  logic       SRD,
  input  logic       SW,
  input  logic       SFA,
  input  logic [6:0] ST,
  input  logic       ack,
  output logic [4:0] grant,
  output logic       grant_valid,
  output logic [2:0] svc_code,
  output logic [4:0] pending,
  output logic       timeout_err
);

  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [HW-1:0] HOLD_V   = HW'(HOLD_CYC);
  localparam logic [TW-1:0] TO_V     = TW'(TIMEOUT_CYC);

  localparam logic [2:0] IDX_FIRE = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  // ------------------------------------------------------------------
  // Debounce: five sources in grant bit order
  // ------------------------------------------------------------------
  logic          temp_oob;
  logic [4:0]    raw;
  logic [4:0]    deb;
  logic [4:0]    deb_d;
  logic [4:0]    rise;
  logic [DW-1:0] deb_cnt [5];

  assign temp_oob = (ST < T_LOW) || (ST > T_HIGH);
  assign raw      = {SFA, temp_oob, SW, SRD, SFD};

  // The counter tracks consecutive samples that disagree with the
  // debounced value; a single agreeing sample restarts the count.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
    end else begin
      deb_d <= deb;
      for (int i = 0; i < 5; i++) begin
        if (raw[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= raw[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Rising edge of a debounced output, one edge after it changes.
  assign rise = deb & ~deb_d;

  // ------------------------------------------------------------------
  // Winner selection from registered pending and pointer
  // ------------------------------------------------------------------
  state_t     state;
  logic [1:0] ptr;
  logic       win_found;
  logic [2:0] win_idx;
  logic [1:0] rr_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = IDX_FIRE;
    rr_idx    = 2'd0;
    if (pending[4]) begin
      win_found = 1'b1;
      win_idx   = IDX_FIRE;
    end else begin
      for (int k = 0; k < 4; k++) begin
        rr_idx = ptr + 2'(k);
        if (!win_found && pending[rr_idx]) begin
          win_found = 1'b1;
          win_idx   = {1'b0, rr_idx};
        end
      end
    end
  end

  function automatic logic [2:0] svc_of(input logic [2:0] idx);
    case (idx)
      3'd0:    svc_of = 3'd1;
      3'd1:    svc_of = 3'd2;
      3'd2:    svc_of = 3'd3;
      3'd3:    svc_of = 3'd5;
      3'd4:    svc_of = 3'd4;
      default: svc_of = 3'd0;
    endcase
  endfunction

  // ------------------------------------------------------------------
  // Grant state machine
  // ------------------------------------------------------------------
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] to_cnt;
  logic [HW-1:0] hold_nxt;
  logic [TW-1:0] to_nxt;
  logic          ack_seen;
  logic          ack_any;
  logic          preempted;
  logic [2:0]    served_idx;
  logic [4:0]    rel_clr;

  assign hold_nxt = (hold_cnt == HOLD_V) ? hold_cnt : hold_cnt + HW'(1);
  assign to_nxt   = (to_cnt == TO_V) ? to_cnt : to_cnt + TW'(1);

  // An ack on the deciding cycle counts, so a late ack exits without
  // waiting one more cycle.
  assign ack_any = ack_seen | ack;

  // A preempted grant keeps its pending bit; acked or timed-out grants
  // drop theirs on the way out of RELEASE.
  assign rel_clr = (state == S_RELEASE && !preempted) ? (5'b00001 << served_idx) : 5'b00000;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= S_IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      svc_code    <= '0;
      pending     <= '0;
      timeout_err <= 1'b0;
      hold_cnt    <= '0;
      to_cnt      <= '0;
      ack_seen    <= 1'b0;
      preempted   <= 1'b0;
      served_idx  <= '0;
      ptr         <= '0;
    end else begin
      // New rising edges win over a same-cycle clear.
      pending     <= (pending & ~rel_clr) | rise;
      timeout_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant       <= 5'b00001 << win_idx;
            grant_valid <= 1'b1;
            svc_code    <= svc_of(win_idx);
            served_idx  <= win_idx;
            hold_cnt    <= '0;
            to_cnt      <= '0;
            ack_seen    <= 1'b0;
            preempted   <= 1'b0;
            state       <= S_GRANT;
          end
        end

        S_GRANT: begin
          hold_cnt <= hold_nxt;
          to_cnt   <= to_nxt;
          if (ack) ack_seen <= 1'b1;

          if (pending[4] && served_idx != IDX_FIRE) begin
            preempted   <= 1'b1;
            grant       <= '0;
            grant_valid <= 1'b0;
            svc_code    <= '0;
            state       <= S_RELEASE;
          end else if (ack_any && hold_nxt >= HOLD_V) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            svc_code    <= '0;
            state       <= S_RELEASE;
          end else if (!ack_any && to_nxt == TO_V) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            svc_code    <= '0;
            timeout_err <= 1'b1;
            state       <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          // A preempted event was not served, so it keeps its turn.
          if (!preempted && served_idx != IDX_FIRE) begin
            ptr <= served_idx[1:0] + 2'd1;
          end
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_home_event_arbiter.sv
module tb_home_event_arbiter;

  localparam int         HOLD = 8;
  localparam int         TMO  = 20;
  localparam int         DEB  = 3;
  localparam logic [6:0] TLO  = 7'd50;
  localparam logic [6:0] THI  = 7'd85;

  logic       Clk;
  logic       Rst;
  logic       SFD, SRD, SW, SFA, ack;
  logic [6:0] ST;
  logic [4:0] grant;
  logic       grant_valid;
  logic [2:0] svc_code;
  logic [4:0] pending;
  logic       timeout_err;

  home_event_arbiter #(
    .HOLD_CYC(HOLD), .TIMEOUT_CYC(TMO), .DEB_CYC(DEB), .T_LOW(TLO), .T_HIGH(THI)
  ) dut (
    .Clk(Clk), .Rst(Rst), .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA), .ST(ST),
    .ack(ack), .grant(grant), .grant_valid(grant_valid), .svc_code(svc_code),
    .pending(pending), .timeout_err(timeout_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: integer bookkeeping of the arbitration rules
  // ------------------------------------------------------------------
  int m_run[5];
  bit m_deb[5], m_prev[5], m_pend[5];
  int m_phase;   // 0 idle, 1 granting, 2 releasing
  int m_who, m_age, m_ptr;
  bit m_acked, m_pre, m_terr, m_gv, m_ok;
  int code_of[5] = '{1, 2, 3, 5, 4};

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_run[i] = 0; m_deb[i] = 0; m_prev[i] = 0; m_pend[i] = 0;
    end
    m_phase = 0; m_who = 0; m_age = 0; m_ptr = 0;
    m_acked = 0; m_pre = 0; m_terr = 0; m_gv = 0; m_ok = 1;
  endtask

  task automatic model_step();
    bit r[5];
    bit rise[5];
    bit clr[5];
    r = '{SFD, SRD, SW, ((ST < TLO) || (ST > THI)), SFA};
    for (int i = 0; i < 5; i++) begin
      rise[i] = m_deb[i] && !m_prev[i];
      m_prev[i] = m_deb[i];
      clr[i] = 0;
      if (r[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin m_deb[i] = r[i]; m_run[i] = 0; end
      end else begin
        m_run[i] = 0;
      end
    end
    m_terr = 0;
    if (m_phase == 0) begin
      bit found;
      found = 0;
      if (m_pend[4]) begin found = 1; m_who = 4; end
      else begin
        for (int k = 0; k < 4; k++)
          if (!found && m_pend[(m_ptr + k) % 4]) begin found = 1; m_who = (m_ptr + k) % 4; end
      end
      if (found) begin
        m_phase = 1; m_gv = 1; m_age = 0; m_acked = 0; m_pre = 0;
      end
    end else if (m_phase == 1) begin
      m_age++;
      if (ack) m_acked = 1;
      if (m_pend[4] && m_who != 4) begin
        m_pre = 1; m_phase = 2; m_gv = 0;
      end else if (m_acked && m_age >= HOLD) begin
        m_phase = 2; m_gv = 0;
      end else if (!m_acked && m_age >= TMO) begin
        m_phase = 2; m_gv = 0; m_terr = 1;
      end
    end else begin
      if (!m_pre) begin
        clr[m_who] = 1;
        if (m_who != 4) m_ptr = (m_who + 1) % 4;
      end
      m_phase = 0;
    end
    for (int i = 0; i < 5; i++) m_pend[i] = (m_pend[i] && !clr[i]) || rise[i];
  endtask

  initial m_ok = 0;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) model_reset();
    else model_step();
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge Clk) begin
    if (Rst && m_ok) begin
      logic [4:0] eg, ep;
      logic [2:0] es;
      eg = m_gv ? (5'b00001 << m_who) : 5'b00000;
      es = m_gv ? 3'(code_of[m_who]) : 3'd0;
      for (int i = 0; i < 5; i++) ep[i] = m_pend[i];
      chk("cycle", {1'b0, grant, grant_valid, svc_code, pending, timeout_err},
                   {1'b0, eg, m_gv, es, ep, m_terr});
    end
  end

  // ------------------------------------------------------------------
  // Directed helpers
  // ------------------------------------------------------------------
  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic wait_gv(input logic v, input int budget, input string nm);
    int n;
    n = 0;
    while (grant_valid !== v && n < budget) begin tick(); n++; end
    chk(nm, {15'd0, grant_valid}, {15'd0, v});
  endtask

  task automatic collect_rr(input string nm);
    logic [2:0] exp_codes [3];
    exp_codes = '{3'd1, 3'd2, 3'd3};
    ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_gv(1'b1, 40, "rr_wait_grant");
      chk(nm, {13'd0, svc_code}, {13'd0, exp_codes[k]});
      wait_gv(1'b0, 40, "rr_wait_release");
    end
    ack = 1'b0;
  endtask

  initial begin
    int n;
    Rst = 1'b0; SFD = 0; SRD = 0; SW = 0; SFA = 0; ST = 7'd60; ack = 0;
    repeat (3) tick();
    chk("reset_outputs", {1'b0, grant, grant_valid, svc_code, pending, timeout_err}, 16'd0);
    Rst = 1'b1;
    repeat (3) tick();

    // Glitch of two samples is rejected.
    SFD = 1; tick(); tick(); SFD = 0;
    repeat (6) tick();
    chk("glitch_pending", {11'd0, pending}, 16'd0);
    chk("glitch_no_grant", {15'd0, grant_valid}, 16'd0);

    // Round-robin from front, then again after the pointer wraps.
    SFD = 1; SRD = 1; SW = 1;
    collect_rr("rr_first_round");
    SFD = 0; SRD = 0; SW = 0;
    repeat (8) tick();
    SFD = 1; SRD = 1; SW = 1;
    collect_rr("rr_second_round");
    SFD = 0; SRD = 0; SW = 0;
    repeat (8) tick();

    // Three-sample pulse: pending at E+3, grant at E+4, hold with ack at cycle 2.
    SFD = 1;
    tick(); tick(); tick();
    chk("deb_e2_pending", {11'd0, pending}, 16'd0);
    SFD = 0;
    tick();
    chk("deb_e3_pending", {11'd0, pending}, 16'h0001);
    chk("deb_e3_no_grant", {15'd0, grant_valid}, 16'd0);
    tick();
    chk("deb_e4_grant", {8'd0, grant, svc_code}, {8'd0, 5'b00001, 3'd1});
    n = 0;
    while (grant_valid && n < 40) begin
      n++;
      ack = (n == 2);
      tick();
    end
    ack = 0;
    chk("hold_len", 16'(n), 16'd8);
    tick();
    chk("hold_pending_cleared", {11'd0, pending}, 16'd0);
    repeat (4) tick();

    // Fire preempts a window grant, then window resumes.
    SW = 1;
    wait_gv(1'b1, 20, "pre_wait_window");
    chk("pre_window_svc", {13'd0, svc_code}, 16'd3);
    tick(); tick();
    SFA = 1;
    wait_gv(1'b0, 20, "pre_release");
    chk("pre_pending_kept", {11'd0, pending}, 16'h0014);
    wait_gv(1'b1, 20, "pre_wait_fire");
    chk("pre_fire_svc", {8'd0, grant, svc_code}, {8'd0, 5'b10000, 3'd4});
    ack = 1;
    wait_gv(1'b0, 20, "pre_fire_release");
    wait_gv(1'b1, 20, "pre_wait_regrant");
    chk("pre_regrant_svc", {13'd0, svc_code}, 16'd3);
    wait_gv(1'b0, 20, "pre_regrant_release");
    ack = 0; SW = 0; SFA = 0;
    repeat (8) tick();

    // Temperature timeout.
    ST = 7'd30;
    wait_gv(1'b1, 20, "to_wait_grant");
    chk("to_svc", {13'd0, svc_code}, 16'd5);
    n = 0;
    while (grant_valid && n < 60) begin n++; tick(); end
    chk("to_len", 16'(n), 16'd20);
    chk("to_pulse_high", {15'd0, timeout_err}, 16'd1);
    tick();
    chk("to_pulse_low_pending", {10'd0, timeout_err, pending}, 16'd0);
    repeat (10) tick();
    chk("to_no_regrant", {15'd0, grant_valid}, 16'd0);
    ST = 7'd60;
    repeat (6) tick();

    // Reset mid-grant.
    SRD = 1;
    wait_gv(1'b1, 20, "rst_wait_grant");
    tick(); tick();
    #2;
    Rst = 0; SRD = 0;
    #1;
    chk("rst_async_clear", {1'b0, grant, grant_valid, svc_code, pending, timeout_err}, 16'd0);
    tick(); tick();
    Rst = 1;
    n = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (grant_valid || pending != 0) n++;
    end
    chk("rst_quiet_after", 16'(n), 16'd0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      int ack_div;
      ack_div = ((c / 500) % 2 == 0) ? 4 : 40;
      if ($urandom_range(0, 15) == 0) SFD = ~SFD;
      if ($urandom_range(0, 15) == 0) SRD = ~SRD;
      if ($urandom_range(0, 15) == 0) SW  = ~SW;
      if ($urandom_range(0, 63) == 0) SFA = ~SFA;
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 7))
          0: ST = 7'd30;
          1: ST = 7'd49;
          2: ST = 7'd50;
          3: ST = 7'd70;
          4: ST = 7'd85;
          5: ST = 7'd86;
          6: ST = 7'd100;
          default: ST = 7'($urandom_range(0, 127));
        endcase
      end
      ack = ($urandom_range(0, ack_div - 1) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
